// File: rtl/park_space_register.sv
// Parking free-space register with entry/exit req/ack channels.
// Optional PARK_STATS_EN adds entry_total, reject_total and peak_occupancy outputs.

module park_space_chan (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ok,
  output logic take,
  output logic ack,
  output logic err
);
  typedef enum logic [1:0] {IDLE, RESP, WAIT_LOW} state_t;
  state_t state;

  assign take = (state == IDLE) && req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          state <= RESP;
          ack   <= ok;
          err   <= !ok;
        end
        RESP:     state <= WAIT_LOW;
        WAIT_LOW: if (!req) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

module park_space_register #(
  parameter int                NUM_W     = 3,
  parameter int                SPACES    = 8,
  parameter logic [SPACES-1:0] INIT_FREE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter_req,
  input  logic [NUM_W-1:0]  enter_number,
  input  logic              exit_req,
  input  logic [NUM_W-1:0]  exit_number,
  output logic              enter_ack,
  output logic              enter_err,
  output logic              exit_ack,
  output logic              exit_err,
  output logic [SPACES-1:0] parking_capacity,
  output logic [NUM_W:0]    free_count,
  output logic              full,
  output logic              empty
`ifdef PARK_STATS_EN
  ,
  output logic [15:0]       entry_total,
  output logic [7:0]        reject_total,
  output logic [NUM_W:0]    peak_occupancy
`endif
);
  localparam int NCAP = 2**NUM_W;
  localparam int CW   = NUM_W + 1;

  function automatic logic [NUM_W:0] popcount(input logic [SPACES-1:0] v);
    popcount = '0;
    for (int i = 0; i < SPACES; i++) popcount = popcount + CW'(v[i]);
  endfunction

  // channel 0 = exit, channel 1 = entry
  logic [1:0] req_v, ok_v, take_v, ack_v, err_v;
  assign req_v = {enter_req, exit_req};

  for (genvar c = 0; c < 2; c++) begin : g_chan
    park_space_chan u_chan (
      .clk  (clk),
      .reset(reset),
      .req  (req_v[c]),
      .ok   (ok_v[c]),
      .take (take_v[c]),
      .ack  (ack_v[c]),
      .err  (err_v[c])
    );
  end

  assign {enter_ack, exit_ack} = ack_v;
  assign {enter_err, exit_err} = err_v;

  // Padded copies so any NUM_W-bit index is in range; range is checked separately.
  logic [NCAP-1:0]   cap_ext, mid_ext, ex_oh, en_oh;
  logic [SPACES-1:0] ex_mask, en_mask, cap_mid, cap_next;
  logic              ex_in_range, en_in_range, exit_ok, enter_ok;

  always_comb begin
    ex_in_range = 32'(exit_number) < SPACES;
    en_in_range = 32'(enter_number) < SPACES;
    ex_oh       = NCAP'(1) << exit_number;
    en_oh       = NCAP'(1) << enter_number;
    ex_mask     = SPACES'(ex_oh);
    en_mask     = SPACES'(en_oh);
    cap_ext     = NCAP'(parking_capacity);
    // Exit is resolved first; entry then sees the post-exit vector.
    exit_ok     = ex_in_range && !cap_ext[exit_number];
    cap_mid     = parking_capacity | ((take_v[0] && exit_ok) ? ex_mask : '0);
    mid_ext     = NCAP'(cap_mid);
    enter_ok    = en_in_range && mid_ext[enter_number];
    cap_next    = cap_mid & ~((take_v[1] && enter_ok) ? en_mask : '0);
  end

  assign ok_v = {enter_ok, exit_ok};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parking_capacity <= INIT_FREE;
      free_count       <= popcount(INIT_FREE);
    end else begin
      parking_capacity <= cap_next;
      free_count       <= free_count + CW'(take_v[0] && exit_ok) - CW'(take_v[1] && enter_ok);
    end
  end

  assign full  = (free_count == '0);
  assign empty = (free_count == CW'(SPACES));

`ifdef PARK_STATS_EN
  logic [8:0]     rej_sum;
  logic [NUM_W:0] occupancy;
  assign rej_sum   = {1'b0, reject_total} + 9'(enter_err) + 9'(exit_err);
  assign occupancy = CW'(SPACES) - free_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_total    <= '0;
      reject_total   <= '0;
      peak_occupancy <= '0;
    end else begin
      if (enter_ack && entry_total != 16'hFFFF) entry_total <= entry_total + 16'd1;
      reject_total <= rej_sum[8] ? 8'hFF : rej_sum[7:0];
      if (occupancy > peak_occupancy) peak_occupancy <= occupancy;
    end
  end
`endif
endmodule

// File: tb/tb_park_space_register.sv
// Directed bench for park_space_register: vector table plus hand sequences.

module tb_park_space_register;
  logic       clk = 1'b0;
  logic       reset;
  logic       enter_req, exit_req;
  logic [2:0] enter_number, exit_number;
  logic       enter_ack, enter_err, exit_ack, exit_err, full, empty;
  logic [7:0] parking_capacity;
  logic [3:0] free_count;

  logic       enter_req6;
  logic [2:0] enter_number6;
  logic       exit_req6;
  logic [2:0] exit_number6;
  logic       enter_ack6, enter_err6, exit_ack6, exit_err6, full6, empty6;
  logic [5:0] parking_capacity6;
  logic [3:0] free_count6;

`ifdef PARK_STATS_EN
  logic [15:0] entry_total, entry_total6;
  logic [7:0]  reject_total, reject_total6;
  logic [3:0]  peak_occupancy, peak_occupancy6;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  park_space_register u_dut (
    .clk(clk), .reset(reset),
    .enter_req(enter_req), .enter_number(enter_number),
    .exit_req(exit_req), .exit_number(exit_number),
    .enter_ack(enter_ack), .enter_err(enter_err),
    .exit_ack(exit_ack), .exit_err(exit_err),
    .parking_capacity(parking_capacity), .free_count(free_count),
    .full(full), .empty(empty)
`ifdef PARK_STATS_EN
    , .entry_total(entry_total), .reject_total(reject_total), .peak_occupancy(peak_occupancy)
`endif
  );

  park_space_register #(.NUM_W(3), .SPACES(6), .INIT_FREE(6'h3F)) u_dut6 (
    .clk(clk), .reset(reset),
    .enter_req(enter_req6), .enter_number(enter_number6),
    .exit_req(exit_req6), .exit_number(exit_number6),
    .enter_ack(enter_ack6), .enter_err(enter_err6),
    .exit_ack(exit_ack6), .exit_err(exit_err6),
    .parking_capacity(parking_capacity6), .free_count(free_count6),
    .full(full6), .empty(empty6)
`ifdef PARK_STATS_EN
    , .entry_total(entry_total6), .reject_total(reject_total6), .peak_occupancy(peak_occupancy6)
`endif
  );

  typedef struct {
    logic       ent;
    logic [2:0] en_num;
    logic       ext;
    logic [2:0] ex_num;
    logic       e_ack, e_err, x_ack, x_err;
    logic [7:0] cap;
    logic [3:0] cnt;
    logic       fl, em;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] cap, input logic [3:0] cnt,
                             input logic fl, input logic em);
    chk({tag, " cap"},   32'(parking_capacity), 32'(cap));
    chk({tag, " count"}, 32'(free_count),       32'(cnt));
    chk({tag, " full"},  32'(full),             32'(fl));
    chk({tag, " empty"}, 32'(empty),            32'(em));
  endtask

  // Present one request pair, check the response cycle, then finish the handshake.
  task automatic do_req(input logic ent, input logic [2:0] en, input logic ext, input logic [2:0] ex);
    @(negedge clk);
    enter_req = ent; enter_number = en;
    exit_req  = ext; exit_number  = ex;
    @(posedge clk); #1;
  endtask

  task automatic release_req();
    @(negedge clk);
    enter_req = 1'b0; exit_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    int acks;
    vecs[0]  = '{1, 3'd2, 1, 3'd2, 1, 0, 0, 1, 8'hF3, 4'd6, 0, 0};
    vecs[1]  = '{0, 3'd0, 1, 3'd2, 0, 0, 1, 0, 8'hF7, 4'd7, 0, 0};
    vecs[2]  = '{1, 3'd3, 0, 3'd0, 0, 1, 0, 0, 8'hF7, 4'd7, 0, 0};
    vecs[3]  = '{1, 3'd0, 0, 3'd0, 1, 0, 0, 0, 8'hF6, 4'd6, 0, 0};
    vecs[4]  = '{1, 3'd1, 0, 3'd0, 1, 0, 0, 0, 8'hF4, 4'd5, 0, 0};
    vecs[5]  = '{1, 3'd2, 0, 3'd0, 1, 0, 0, 0, 8'hF0, 4'd4, 0, 0};
    vecs[6]  = '{1, 3'd4, 1, 3'd0, 1, 0, 1, 0, 8'hE1, 4'd4, 0, 0};
    vecs[7]  = '{1, 3'd4, 1, 3'd4, 1, 0, 1, 0, 8'hE1, 4'd4, 0, 0};
    vecs[8]  = '{1, 3'd0, 1, 3'd0, 1, 0, 0, 1, 8'hE0, 4'd3, 0, 0};
    vecs[9]  = '{1, 3'd5, 0, 3'd0, 1, 0, 0, 0, 8'hC0, 4'd2, 0, 0};
    vecs[10] = '{1, 3'd6, 0, 3'd0, 1, 0, 0, 0, 8'h80, 4'd1, 0, 0};
    vecs[11] = '{1, 3'd7, 0, 3'd0, 1, 0, 0, 0, 8'h00, 4'd0, 1, 0};
    vecs[12] = '{1, 3'd5, 0, 3'd0, 0, 1, 0, 0, 8'h00, 4'd0, 1, 0};

    enter_req = 0; exit_req = 0; enter_number = 0; exit_number = 0;
    enter_req6 = 0; exit_req6 = 0; enter_number6 = 0; exit_number6 = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'hFF, 4'd8, 1'b0, 1'b1);
    chk("reset pulses", 32'({enter_ack, enter_err, exit_ack, exit_err}), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Reset while the ack for space 1 is on the wire.
    do_req(1, 3'd1, 0, 3'd0);
    chk("pre-reset ack", 32'(enter_ack), 32'h1);
    chk("pre-reset cap", 32'(parking_capacity), 32'hFD);
    reset = 1'b1; #1;
    chk("mid reset ack cut", 32'(enter_ack), 32'h0);
    check_state("mid reset", 8'hFF, 4'd8, 1'b0, 1'b1);
    enter_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post reset no ack", 32'(enter_ack), 32'h0);

`ifdef PARK_STATS_EN
    chk("stats entry clr",  32'(entry_total),    32'h0);
    chk("stats reject clr", 32'(reject_total),   32'h0);
    chk("stats peak clr",   32'(peak_occupancy), 32'h0);
    for (int s = 0; s < 3; s++) begin
      do_req(1, 3'(s), 0, 3'd0);
      release_req();
    end
    do_req(1, 3'd0, 0, 3'd0); release_req();
    do_req(0, 3'd0, 1, 3'd7); release_req();
    @(posedge clk); #1;
    chk("stats entry",  32'(entry_total),    32'd3);
    chk("stats reject", 32'(reject_total),   32'd2);
    chk("stats peak",   32'(peak_occupancy), 32'd3);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
`endif

    // Entry on space 3 held for 4 cycles: exactly one ack.
    do_req(1, 3'd3, 0, 3'd0);
    acks = 0;
    chk("hold ack", 32'(enter_ack), 32'h1);
    check_state("hold", 8'hF7, 4'd7, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (enter_ack) acks++;
    end
    chk("hold no repeat ack", 32'(acks), 32'h0);
    release_req();
    check_state("hold after", 8'hF7, 4'd7, 1'b0, 1'b0);

    // Undo the vecs[0] setup: space 2 is entered; space 3 exits on the same edge.
    // vecs[0] exercises a different-space pair: enter 2 ok, exit 2 err? no -> exit 3.
    vecs[0] = '{1, 3'd2, 1, 3'd3, 1, 0, 1, 0, 8'hFB, 4'd7, 0, 0};
    vecs[1] = '{1, 3'd3, 1, 3'd2, 1, 0, 1, 0, 8'hF7, 4'd7, 0, 0};

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_req(vecs[i].ent, vecs[i].en_num, vecs[i].ext, vecs[i].ex_num);
      chk({tag, " enter_ack"}, 32'(enter_ack), 32'(vecs[i].e_ack));
      chk({tag, " enter_err"}, 32'(enter_err), 32'(vecs[i].e_err));
      chk({tag, " exit_ack"},  32'(exit_ack),  32'(vecs[i].x_ack));
      chk({tag, " exit_err"},  32'(exit_err),  32'(vecs[i].x_err));
      check_state(tag, vecs[i].cap, vecs[i].cnt, vecs[i].fl, vecs[i].em);
      release_req();
    end

    // Free space 5 from a full lot.
    do_req(0, 3'd0, 1, 3'd5);
    chk("exit5 ack", 32'(exit_ack), 32'h1);
    check_state("exit5", 8'h20, 4'd1, 1'b0, 1'b0);
    release_req();

    // Exit of a free space on a fresh lot.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    do_req(0, 3'd0, 1, 3'd2);
    chk("exit free err", 32'(exit_err), 32'h1);
    check_state("exit free", 8'hFF, 4'd8, 1'b0, 1'b1);
    release_req();

    // Six-space lot: numbers 6 and 7 are out of range.
    @(negedge clk);
    enter_req6 = 1'b1; enter_number6 = 3'd7;
    exit_req6  = 1'b1; exit_number6  = 3'd6;
    @(posedge clk); #1;
    chk("six enter7 err", 32'(enter_err6), 32'h1);
    chk("six enter7 ack", 32'(enter_ack6), 32'h0);
    chk("six exit6 err",  32'(exit_err6),  32'h1);
    chk("six cap",        32'(parking_capacity6), 32'h3F);
    chk("six count",      32'(free_count6), 32'd6);
    chk("six empty",      32'(empty6), 32'h1);
    @(negedge clk); enter_req6 = 1'b0; exit_req6 = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/park_space_register.md
Name: park_space_register

Overview:
- Sequential counterpart of the parking priority encoder: it consumes a space number and maintains the 8-bit free-space vector that the encoder reads.
- Entry and exit gates each request a state change on one space over a four-phase req/ack handshake.
- The block marks the space occupied (entry) or free (exit), flags illegal requests, and publishes capacity, free count, full and empty status.

Parameters:
- SPACES, 8: number of parking spaces; must be ≤ 2^NUM_W.
- NUM_W, 3: width of a space number.
- INIT_FREE, 8'hFF: capacity vector loaded at reset; bit i = 1 means space i is free.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enter_req  input  1  entry gate request; level held until enter_ack or enter_err is seen.
- enter_number  input  NUM_W  space to occupy; stable while enter_req is high.
- exit_req  input  1  exit gate request; same rules as enter_req.
- exit_number  input  NUM_W  space to release; stable while exit_req is high.
- enter_ack  output  1  one-cycle pulse: entry accepted.
- enter_err  output  1  one-cycle pulse: entry rejected.
- exit_ack  output  1  one-cycle pulse: exit accepted.
- exit_err  output  1  one-cycle pulse: exit rejected.
- parking_capacity  output  SPACES  registered free-space vector; 1 = free.
- free_count  output  NUM_W+1  population count of parking_capacity, registered.
- full  output  1  high when free_count == 0.
- empty  output  1  high when free_count == SPACES.

Behaviour:
- Reset (asynchronous, active-high):
  - parking_capacity = INIT_FREE; free_count = popcount(INIT_FREE).
  - full and empty follow free_count; all ack/err = 0.
  - Both channel FSMs go to IDLE. Reset mid-handshake discards the request.
- Each channel has its own FSM with states IDLE, RESP, WAIT_LOW.
- IDLE → RESP when req = 1 at a clock edge.
  - The same edge registers the decision and the capacity update.
  - ack or err is high for exactly the one cycle spent in RESP.
  - Latency: the pulse is visible in the cycle after the edge that sampled req.
- RESP → WAIT_LOW unconditionally.
- WAIT_LOW → IDLE when req = 0 is sampled.
  - A req still high in WAIT_LOW is ignored, so no double processing.
  - Minimum spacing between two requests on one channel is 3 cycles.
- Entry decision:
  - Accept if number < SPACES and capacity[number] = 1. Clear the bit, decrement free_count, pulse enter_ack.
  - Otherwise (out of range, space occupied, or lot full) pulse enter_err; capacity unchanged.
- Exit decision:
  - Accept if number < SPACES and capacity[number] = 0. Set the bit, increment free_count, pulse exit_ack.
  - Otherwise pulse exit_err; capacity unchanged.
- Simultaneous requests (both channels leave IDLE on the same edge):
  - Evaluation order is exit first, then entry against the post-exit vector.
  - Different spaces: both updates apply in the same cycle.
  - Same space, currently occupied: exit frees it, entry re-occupies it. Both acks fire; bit stays 0; free_count unchanged.
  - Same space, currently free: exit_err; entry accepted.
- free_count arithmetic:
  - Net change per cycle is −1, 0 or +1.
  - It never wraps, because illegal requests are rejected before the update.
- full and empty are combinational decodes of registered free_count, so they are glitch-free.
- Outputs never take X or Z after reset.

Optional Feature:
- Macro PARK_STATS_EN.
- When defined, three extra output ports exist:
  - entry_total [15:0]: increments on every enter_ack; saturates at 16'hFFFF.
  - reject_total [7:0]: increments on every enter_err or exit_err; saturates at 8'hFF. When both errors fire in the same cycle it increments by 2, saturating.
  - peak_occupancy [NUM_W:0]: holds the maximum of SPACES − free_count seen since reset.
- All three reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset with INIT_FREE = 8'hFF → parking_capacity = 8'hFF, free_count = 8, empty = 1, full = 0, no ack/err pulses.
- enter_req with enter_number = 3, held 4 cycles → exactly one enter_ack pulse 1 cycle after the sampling edge; capacity = 8'hF7; free_count = 7; no second ack while req stays high.
- Occupy all 8 spaces, then enter_req with number 5 → enter_err pulse; full = 1; capacity = 8'h00. Then exit_req with number 5 → exit_ack; capacity = 8'h20; free_count = 1.
- With capacity = 8'hFF, exit_req with number 2 → exit_err; capacity unchanged. With SPACES = 6 (NUM_W = 3), enter_req with number 7 → enter_err.
- With space 4 occupied, enter_req(4) and exit_req(4) sampled on the same edge → exit_ack and enter_ack in the same cycle; capacity bit 4 = 0; free_count unchanged.
- Assert reset during RESP of an enter request on space 1 → capacity returns to INIT_FREE immediately and the ack pulse is cut. With PARK_STATS_EN defined, the counters clear; after 3 accepted entries and 2 rejects, entry_total = 3, reject_total = 2, peak_occupancy = 3.
